// File: rtl/etc_pkg.sv
// Shared definitions for the two-lane Epass checker arbiter: FSM encoding, lane count, lane index width.
package etc_pkg;
  localparam int NUM_LANES = 2;
  localparam int LANE_W    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot = '0;
    lane_onehot[lane] = 1'b1;
  endfunction
endpackage

// File: rtl/etc_timeout_timer.sv
// Checker response timer: counts while enabled, expire flags the last allowed cycle (TIMEOUT_CYC-1).
// Combinational expire, one-cycle clear; no backpressure.
module etc_timeout_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/etc_epass_arbiter.sv
// Round-robin arbiter sharing one Epass checker between two toll lanes; all outputs registered.
// Request to chk_start is one cycle, lane_done follows the checker answer by one cycle; a silent checker is cut off by timeout.
module etc_epass_arbiter
  import etc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int WIDTH_CNT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           lane_req,
  output logic [1:0]           lane_gnt,
  output logic [1:0]           lane_done,
  output logic [1:0]           lane_pass,
  output logic                 chk_start,
  output logic                 chk_lane,
  input  logic                 chk_valid,
  input  logic                 chk_ok,
  output logic                 timeout,
  output logic [WIDTH_CNT-1:0] pass_cnt,
  output logic [WIDTH_CNT-1:0] fail_cnt
);
  state_t              state, state_nxt;
  logic [LANE_W-1:0]   rr, rr_nxt;
  logic [LANE_W-1:0]   sel_nxt;
  logic [1:0]          gnt_nxt, done_nxt, pass_nxt;
  logic                start_nxt, tmo_nxt;
  logic [WIDTH_CNT-1:0] pass_cnt_nxt, fail_cnt_nxt;
  logic                tmr_clr, tmr_en, tmr_expire;

  etc_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr;
    sel_nxt      = chk_lane;
    gnt_nxt      = lane_gnt;
    done_nxt     = 2'b00;
    pass_nxt     = lane_pass;
    start_nxt    = 1'b0;
    tmo_nxt      = 1'b0;
    pass_cnt_nxt = pass_cnt;
    fail_cnt_nxt = fail_cnt;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && (lane_req != 2'b00)) begin
          // rr only breaks ties; a lone requester wins outright
          sel_nxt   = (lane_req == 2'b11) ? rr : LANE_W'(lane_req[1]);
          gnt_nxt   = lane_onehot(sel_nxt);
          start_nxt = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tmr_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (chk_valid) begin
          done_nxt           = lane_onehot(chk_lane);
          pass_nxt[chk_lane] = chk_ok;
          if (chk_ok) pass_cnt_nxt = pass_cnt + WIDTH_CNT'(1);
          else        fail_cnt_nxt = fail_cnt + WIDTH_CNT'(1);
          state_nxt = ST_RESP;
        end else if (tmr_expire) begin
          done_nxt           = lane_onehot(chk_lane);
          pass_nxt[chk_lane] = 1'b0;
          fail_cnt_nxt       = fail_cnt + WIDTH_CNT'(1);
          tmo_nxt            = 1'b1;
          state_nxt          = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_nxt   = 2'b00;
        rr_nxt    = ~chk_lane;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr        <= '0;
      chk_lane  <= 1'b0;
      lane_gnt  <= 2'b00;
      lane_done <= 2'b00;
      lane_pass <= 2'b00;
      chk_start <= 1'b0;
      timeout   <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      rr        <= rr_nxt;
      chk_lane  <= sel_nxt;
      lane_gnt  <= gnt_nxt;
      lane_done <= done_nxt;
      lane_pass <= pass_nxt;
      chk_start <= start_nxt;
      timeout   <= tmo_nxt;
      pass_cnt  <= pass_cnt_nxt;
      fail_cnt  <= fail_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_etc_epass_arbiter.sv
// Directed bench for etc_epass_arbiter with a short timeout and 3-bit counters so wrap is reachable.
module tb_etc_epass_arbiter;
  localparam int TO = 8;
  localparam int WC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    lane_req = 2'b00;
  logic [1:0]    lane_gnt, lane_done, lane_pass;
  logic          chk_start, chk_lane, timeout;
  logic          chk_valid = 1'b0;
  logic          chk_ok = 1'b0;
  logic [WC-1:0] pass_cnt, fail_cnt;

  int checks = 0;
  int failures = 0;
  int exp_pass = 0;
  int exp_fail = 0;
  int lat;
  int starts;

  etc_epass_arbiter #(.TIMEOUT_CYC(TO), .WIDTH_CNT(WC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .lane_req  (lane_req),
    .lane_gnt  (lane_gnt),
    .lane_done (lane_done),
    .lane_pass (lane_pass),
    .chk_start (chk_start),
    .chk_lane  (chk_lane),
    .chk_valid (chk_valid),
    .chk_ok    (chk_ok),
    .timeout   (timeout),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
  endtask

  // pulse a request long enough to be sampled in IDLE, then drop it
  task automatic go(input logic [1:0] m);
    tick();
    lane_req = m;
    tick();
    lane_req = 2'b00;
  endtask

  // find chk_start, answer dly cycles after START (if resp), return START-to-done latency
  task automatic txn(input int lane, input int dly, input logic resp, input logic ok, output int l);
    int n = 0;
    while (chk_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(chk_start), 1);
    chk("chk_lane", 32'(chk_lane), lane);
    chk("gnt_start", 32'(lane_gnt), 1 << lane);
    l = 0;
    while (lane_done === 2'b00 && l < 30) begin
      chk_valid = resp && (l == dly);
      chk_ok = ok;
      tick();
      l++;
    end
    chk_valid = 1'b0;
    chk("done_onehot", 32'(lane_done), 1 << lane);
  endtask

  task automatic fin(input int lane, input logic pv, input logic tv);
    if (pv) exp_pass++;
    else    exp_fail++;
    chk("lane_pass", 32'(lane_pass[lane]), 32'(pv));
    chk("timeout", 32'(timeout), 32'(tv));
    chk("pass_cnt", 32'(pass_cnt), exp_pass % (1 << WC));
    chk("fail_cnt", 32'(fail_cnt), exp_fail % (1 << WC));
  endtask

  initial begin
    do_reset();
    chk("rst_gnt", 32'(lane_gnt), 0);
    chk("rst_done", 32'(lane_done), 0);
    chk("rst_pass", 32'(lane_pass), 0);
    chk("rst_start", 32'(chk_start), 0);
    chk("rst_lane", 32'(chk_lane), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_pcnt", 32'(pass_cnt), 0);
    chk("rst_fcnt", 32'(fail_cnt), 0);

    // single lane 0 pass; request dropped right after sampling
    enable = 1'b1;
    go(2'b01);
    txn(0, 2, 1'b1, 1'b1, lat);
    chk("t1_lat", lat, 3);
    fin(0, 1'b1, 1'b0);
    chk("t1_gnt_resp", 32'(lane_gnt), 2'b01);
    tick();
    chk("t1_gnt_clr", 32'(lane_gnt), 0);
    chk("t1_done_clr", 32'(lane_done), 0);
    chk("t1_pass_hold", 32'(lane_pass), 2'b01);

    // continuous requests on both lanes alternate from lane 0
    do_reset();
    lane_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      txn(i % 2, 1, 1'b1, 1'b1, lat);
      chk("t2_lat", lat, 2);
      fin(i % 2, 1'b1, 1'b0);
    end
    lane_req = 2'b00;

    // disabled: no starts, then lane 0 granted on the cycle after enable
    enable = 1'b0;
    lane_req = 2'b11;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (chk_start) starts++;
    end
    chk("t3_no_start", starts, 0);
    enable = 1'b1;
    tick();
    chk("t3_start", 32'(chk_start), 1);
    chk("t3_lane", 32'(chk_lane), 0);
    lane_req = 2'b00;
    txn(0, 1, 1'b1, 1'b1, lat);
    fin(0, 1'b1, 1'b0);

    // timeout on lane 1: 8 WAIT cycles, done in the cycle after
    go(2'b10);
    txn(1, 0, 1'b0, 1'b0, lat);
    chk("t4_lat", lat, TO + 1);
    fin(1, 1'b0, 1'b1);
    tick();
    chk("t4_tmo_pulse", 32'(timeout), 0);

    // answer in the final WAIT cycle wins over timeout
    go(2'b01);
    txn(0, TO, 1'b1, 1'b1, lat);
    chk("t5_lat", lat, TO + 1);
    fin(0, 1'b1, 1'b0);
    tick();
    chk_valid = 1'b1;
    chk_ok = 1'b1;
    tick();
    chk_valid = 1'b0;
    tick();
    chk("t5_idle_done", 32'(lane_done), 0);
    chk("t5_idle_start", 32'(chk_start), 0);
    chk("t5_idle_pcnt", 32'(pass_cnt), exp_pass % (1 << WC));

    // checker rejects lane 1
    go(2'b10);
    txn(1, 1, 1'b1, 1'b0, lat);
    fin(1, 1'b0, 1'b0);
    chk("t5_pass_vec", 32'(lane_pass), 2'b01);

    // asynchronous reset during WAIT
    go(2'b01);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_gnt", 32'(lane_gnt), 0);
    chk("t6_pass", 32'(lane_pass), 0);
    chk("t6_pcnt", 32'(pass_cnt), 0);
    chk("t6_fcnt", 32'(fail_cnt), 0);
    tick();
    reset = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    chk("t6_done", 32'(lane_done), 0);
    go(2'b10);
    txn(1, 1, 1'b1, 1'b1, lat);
    fin(1, 1'b1, 1'b0);

    // seven more passes take the 3-bit pass counter from 1 through 7 back to 0
    lane_req = 2'b11;
    for (int i = 0; i < 7; i++) begin
      txn(i % 2, 1, 1'b1, 1'b1, lat);
      fin(i % 2, 1'b1, 1'b0);
    end
    lane_req = 2'b00;
    chk("t6_wrap", 32'(pass_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
